// File: rtl/graph_mem_pkg.sv
// graph_mem_pkg: shared types, widths and helpers for the graph CSR memory arbiter.
package graph_mem_pkg;
  localparam int GMEM_WORD_W = 32;
  localparam int GMEM_TAG_W  = 8;
  localparam int NUM_LANES   = 3;
  typedef enum logic [1:0] {LANE_IDX, LANE_DA, LANE_DB} lane_e;
  typedef enum logic {KIND_DATA = 1'b0, KIND_IDX = 1'b1} req_kind_e;
  typedef struct packed {
    logic                   valid;
    logic [GMEM_WORD_W-1:0] data;
    logic [GMEM_TAG_W-1:0]  proc;
  } resp_t;
  function automatic logic [GMEM_WORD_W-1:0] sat_inc(input logic [GMEM_WORD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/graph_mem_arbiter_ram.sv
// graph_mem_sp_ram / graph_mem_dp_ram: RAM wrappers with a LAT-deep resettable read pipeline.
module graph_mem_sp_ram #(
  parameter  int DEPTH     = 4096,
  parameter  int W         = 32,
  parameter  int LAT       = 2,
  parameter      INIT_FILE = "",
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] pipe_q [LAT];
  always_ff @(posedge clk_i)
    if (we_i) mem[addr_i] <= wdata_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= mem[addr_i];
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  assign rdata_o = pipe_q[LAT-1];
endmodule

module graph_mem_dp_ram #(
  parameter  int DEPTH     = 16384,
  parameter  int W         = 32,
  parameter  int LAT       = 2,
  parameter      INIT_FILE = "",
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_a_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [W-1:0]  wdata_a_i,
  output logic [W-1:0]  rdata_a_o,
  input  logic          we_b_i,
  input  logic [AW-1:0] addr_b_i,
  input  logic [W-1:0]  wdata_b_i,
  output logic [W-1:0]  rdata_b_o
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] pipe_a_q [LAT];
  logic [W-1:0] pipe_b_q [LAT];
  always_ff @(posedge clk_i) begin
    if (we_a_i) mem[addr_a_i] <= wdata_a_i;
    if (we_b_i) mem[addr_b_i] <= wdata_b_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_a_q[i] <= '0;
        pipe_b_q[i] <= '0;
      end
    end else begin
      pipe_a_q[0] <= mem[addr_a_i];
      pipe_b_q[0] <= mem[addr_b_i];
      for (int i = 1; i < LAT; i++) begin
        pipe_a_q[i] <= pipe_a_q[i-1];
        pipe_b_q[i] <= pipe_b_q[i-1];
      end
    end
  assign rdata_a_o = pipe_a_q[LAT-1];
  assign rdata_b_o = pipe_b_q[LAT-1];
endmodule

// File: rtl/graph_mem_arbiter_rr.sv
// rr_arbiter: round-robin arbiter; search starts at ptr, ptr moves past the winner.
module rr_arbiter #(
  parameter  int N  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            j;
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = IW'(j);
      end
    end
    ptr_d = !found ? ptr_q : (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
endmodule

// File: rtl/graph_mem_arbiter.sv
// graph_mem_arbiter: arbitrates per-processor reads onto IDX / DATA_A / DATA_B lanes with tagged responses.
// Optional GMEM_ARB_STATS_EN adds saturating per-lane grant and stall counters.
module graph_mem_arbiter
  import graph_mem_pkg::*;
#(
  parameter  int NUM_PROCS  = 16,
  parameter  int DATA_DEPTH = 16384,
  parameter  int IDX_DEPTH  = 4096,
  parameter  int READ_LAT   = 2,
  parameter      DATA_INIT  = "out_addrs.mem",
  parameter      IDX_INIT   = "out_vidx.mem",
  localparam int PROC_BITS  = $clog2(NUM_PROCS)
) (
  input  logic                                  clk_in,
  input  logic                                  rst_n_in,
  input  logic [NUM_PROCS-1:0]                  req_valid_in,
  input  logic [NUM_PROCS-1:0]                  req_kind_in,
  input  logic [NUM_PROCS-1:0][GMEM_WORD_W-1:0] req_addr_in,
  output logic [NUM_PROCS-1:0]                  req_ready_out,
  output logic                                  idx_valid_out,
  output logic [GMEM_WORD_W-1:0]                idx_data_out,
  output logic [PROC_BITS-1:0]                  idx_proc_out,
  output logic                                  da_valid_out,
  output logic [GMEM_WORD_W-1:0]                da_data_out,
  output logic [PROC_BITS-1:0]                  da_proc_out,
  output logic                                  db_valid_out,
  output logic [GMEM_WORD_W-1:0]                db_data_out,
  output logic [PROC_BITS-1:0]                  db_proc_out
`ifdef GMEM_ARB_STATS_EN
  ,
  output logic [NUM_LANES-1:0][GMEM_WORD_W-1:0] stat_grants_out,
  output logic [NUM_LANES-1:0][GMEM_WORD_W-1:0] stat_stalls_out
`endif
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int IAW = $clog2(IDX_DEPTH);
  logic [NUM_LANES-1:0][NUM_PROCS-1:0]               elig, grant;
  logic [NUM_LANES-1:0][PROC_BITS-1:0]               gidx;
  logic [NUM_LANES-1:0][READ_LAT-1:0]                vld_q;
  logic [NUM_LANES-1:0][READ_LAT-1:0][PROC_BITS-1:0] tag_q;
  logic [NUM_LANES-1:0][GMEM_WORD_W-1:0]             rdata;
  // Static lane split: index reads share one lane, data reads split by processor parity.
  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PROCS; p++) begin
      elig[LANE_IDX][p] = req_valid_in[p] && (req_kind_e'(req_kind_in[p]) == KIND_IDX);
      elig[LANE_DA][p]  = req_valid_in[p] && (req_kind_e'(req_kind_in[p]) == KIND_DATA) && (p % 2 == 0);
      elig[LANE_DB][p]  = req_valid_in[p] && (req_kind_e'(req_kind_in[p]) == KIND_DATA) && (p % 2 == 1);
    end
  end
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rr_arbiter #(.N(NUM_PROCS)) u_arb (
      .clk_i      (clk_in),
      .rst_ni     (rst_n_in),
      .req_i      (elig[l]),
      .grant_o    (grant[l]),
      .grant_idx_o(gidx[l])
    );
  end
  assign req_ready_out = grant[LANE_IDX] | grant[LANE_DA] | grant[LANE_DB];
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        vld_q[l][0] <= |grant[l];
        tag_q[l][0] <= gidx[l];
        for (int i = 1; i < READ_LAT; i++) begin
          vld_q[l][i] <= vld_q[l][i-1];
          tag_q[l][i] <= tag_q[l][i-1];
        end
      end
    end
  graph_mem_sp_ram #(.DEPTH(IDX_DEPTH), .W(GMEM_WORD_W), .LAT(READ_LAT), .INIT_FILE(IDX_INIT)) u_idx_ram (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .we_i   (1'b0),
    .addr_i (req_addr_in[gidx[LANE_IDX]][IAW-1:0]),
    .wdata_i('0),
    .rdata_o(rdata[LANE_IDX])
  );
  graph_mem_dp_ram #(.DEPTH(DATA_DEPTH), .W(GMEM_WORD_W), .LAT(READ_LAT), .INIT_FILE(DATA_INIT)) u_data_ram (
    .clk_i    (clk_in),
    .rst_ni   (rst_n_in),
    .we_a_i   (1'b0),
    .addr_a_i (req_addr_in[gidx[LANE_DA]][DAW-1:0]),
    .wdata_a_i('0),
    .rdata_a_o(rdata[LANE_DA]),
    .we_b_i   (1'b0),
    .addr_b_i (req_addr_in[gidx[LANE_DB]][DAW-1:0]),
    .wdata_b_i('0),
    .rdata_b_o(rdata[LANE_DB])
  );
  assign idx_valid_out = vld_q[LANE_IDX][READ_LAT-1];
  assign idx_data_out  = rdata[LANE_IDX];
  assign idx_proc_out  = tag_q[LANE_IDX][READ_LAT-1];
  assign da_valid_out  = vld_q[LANE_DA][READ_LAT-1];
  assign da_data_out   = rdata[LANE_DA];
  assign da_proc_out   = tag_q[LANE_DA][READ_LAT-1];
  assign db_valid_out  = vld_q[LANE_DB][READ_LAT-1];
  assign db_data_out   = rdata[LANE_DB];
  assign db_proc_out   = tag_q[LANE_DB][READ_LAT-1];
`ifdef GMEM_ARB_STATS_EN
  logic [NUM_LANES-1:0][GMEM_WORD_W-1:0] grants_q, stalls_q;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (|grant[l]) grants_q[l] <= sat_inc(grants_q[l]);
        if (|(elig[l] & ~grant[l])) stalls_q[l] <= sat_inc(stalls_q[l]);
      end
    end
  assign stat_grants_out = grants_q;
  assign stat_stalls_out = stalls_q;
`endif
endmodule

// File: tb/tb_graph_mem_arbiter.sv
// tb_graph_mem_arbiter: directed vectors for lane mapping, round-robin, latency, reset flush and truncation.
module tb_graph_mem_arbiter;
  import graph_mem_pkg::*;
  localparam int NP = 16;
  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NP-1:0]       valid, kind, ready;
  logic [NP-1:0][31:0] addr;
  logic                iv, dv, bv;
  logic [31:0]         id, dd, bd;
  logic [3:0]          ip, dp, bp;
  int                  n_vec = 0;
  int                  n_err = 0;
`ifdef GMEM_ARB_STATS_EN
  logic [2:0][31:0]    sg, ss;
`endif
  always #5 clk = ~clk;
  graph_mem_arbiter dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .req_valid_in (valid),
    .req_kind_in  (kind),
    .req_addr_in  (addr),
    .req_ready_out(ready),
    .idx_valid_out(iv),
    .idx_data_out (id),
    .idx_proc_out (ip),
    .da_valid_out (dv),
    .da_data_out  (dd),
    .da_proc_out  (dp),
    .db_valid_out (bv),
    .db_data_out  (bd),
    .db_proc_out  (bp)
`ifdef GMEM_ARB_STATS_EN
    ,
    .stat_grants_out(sg),
    .stat_stalls_out(ss)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    valid = '0;
    kind  = '0;
    addr  = '0;
  endtask
  task automatic req(input int p, input logic k, input logic [31:0] a);
    valid[p] = 1'b1;
    kind[p]  = k;
    addr[p]  = a;
  endtask
  function automatic logic [31:0] dword(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction
  int seq [9] = '{0, 2, 4, 0, 2, 4, 0, 2, 4};
  initial begin
    idle();
    for (int i = 0; i < 32; i++) begin
      dut.u_data_ram.mem[i] = dword(i);
      dut.u_idx_ram.mem[i]  = 32'h100 + 32'(i);
    end
    dut.u_idx_ram.mem[5] = 32'h20;
    repeat (2) @(negedge clk);
    chk("rst_idx", {iv, id, ip}, 0);
    chk("rst_da", {dv, dd, dp}, 0);
    chk("rst_db", {bv, bd, bp}, 0);
    chk("rst_ready", ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single idx request, latency 2, one-cycle pulse
    req(3, 1'b1, 32'd5);
    #1 chk("t1_ready", ready, 16'h0008);
    @(negedge clk); idle();
    chk("t1_lat1", iv, 0);
    @(negedge clk);
    chk("t1_resp", {iv, id, ip}, {1'b1, 32'h20, 4'd3});
    @(negedge clk);
    chk("t1_once", iv, 0);
    // round-robin over procs 0,2,4 on DATA_A
    for (int k = 0; k < 11; k++) begin
      idle();
      if (k < 9) begin
        req(0, 1'b0, 32'd0); req(2, 1'b0, 32'd2); req(4, 1'b0, 32'd4);
        #1 chk("rr_ready", ready, 64'(1 << seq[k]));
      end
      if (k >= 2) chk("rr_resp", {dv, dd, dp}, {1'b1, dword(seq[k-2]), 4'(seq[k-2])});
      chk("rr_db_idle", bv, 0);
      @(negedge clk);
    end
    // three lanes in one cycle
    idle(); req(1, 1'b0, 32'd7); req(2, 1'b0, 32'd8); req(5, 1'b1, 32'd0);
    #1 chk("t3_ready", ready, 16'h0026);
    @(negedge clk); idle();
    @(negedge clk);
    chk("t3_db", {bv, bd, bp}, {1'b1, dword(7), 4'd1});
    chk("t3_da", {dv, dd, dp}, {1'b1, dword(8), 4'd2});
    chk("t3_idx", {iv, id, ip}, {1'b1, 32'h100, 4'd5});
    @(negedge clk);
    // back-to-back stream from proc 6
    for (int k = 0; k < 18; k++) begin
      idle();
      if (k < 16) begin
        req(6, 1'b0, 32'(k));
        #1 chk("st_ready", ready, 16'h0040);
      end
      if (k >= 2) chk("st_resp", {dv, dd, dp}, {1'b1, dword(k - 2), 4'd6});
      @(negedge clk);
    end
    // reset while two reads are in flight
    idle(); req(7, 1'b0, 32'd1); req(8, 1'b1, 32'd2);
    #1 chk("t5_ready", ready, 16'h0180);
    @(negedge clk); idle(); rst_n = 1'b0;
    @(negedge clk);
    chk("t5_flush", {iv, dv, bv}, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_flush", {iv, dv, bv}, 0);
    end
    // pointers back at 0: lowest eligible wins, not the pre-reset successor
    idle(); req(2, 1'b0, 32'd0); req(12, 1'b0, 32'd0); req(1, 1'b0, 32'd0); req(9, 1'b0, 32'd0);
    #1 chk("t5_ptr_data", ready, 16'h0006);
    @(negedge clk); idle(); req(1, 1'b1, 32'd0); req(9, 1'b1, 32'd0);
    #1 chk("t5_ptr_idx", ready, 16'h0002);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    // proc 0 loses to proc 4, then withdraws
    req(0, 1'b0, 32'd0); req(4, 1'b0, 32'd4);
    #1 chk("wd_ready", ready, 16'h0010);
    @(negedge clk); idle();
    #1 chk("wd_ready_gone", ready, 0);
    @(negedge clk);
    chk("wd_resp", {dv, dd, dp}, {1'b1, dword(4), 4'd4});
    @(negedge clk);
    chk("wd_none", dv, 0);
    // upper address bits ignored
    req(10, 1'b0, 32'h0001_4003);
    #1 chk("tr_ready", ready, 16'h0400);
    @(negedge clk); idle();
    @(negedge clk);
    chk("tr_resp", {dv, dd, dp}, {1'b1, dword(3), 4'd10});
    @(negedge clk);
    chk("tr_once", dv, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/graph_mem_arbiter.md
Name: graph_mem_arbiter

Overview:
- Multi-requester front end for the graph CSR storage: row-index memory (single-port) plus edge/data memory (true dual-port).
- Accepts read requests from NUM_PROCS processing elements and arbitrates them onto three memory lanes: IDX, DATA_A and DATA_B.
- Returns each read after a fixed latency, tagged with the originating processor ID.
- Replaces per-processor hand-wired address/valid pairs with a valid/ready request interface and tagged responses.

Parameters:
- NUM_PROCS, 16, number of requesting processors (≥2).
- PROC_BITS, $clog2(NUM_PROCS), localparam; width of processor tag.
- DATA_DEPTH, 16384, data memory entries.
- IDX_DEPTH, 4096, row-index memory entries.
- READ_LAT, 2, RAM read latency in cycles (HIGH_PERFORMANCE mode); tag pipeline depth.
- DATA_INIT, "out_addrs.mem", data memory init file.
- IDX_INIT, "out_vidx.mem", index memory init file.

Ports:
- clk_in, input, 1, single system clock.
- rst_n_in, input, 1, asynchronous active-low reset.
- req_valid_in, input, NUM_PROCS, per-processor request valid.
- req_kind_in, input, NUM_PROCS, 0 = data read, 1 = row-index read.
- req_addr_in, input, NUM_PROCS x 32, per-processor word address.
- req_ready_out, output, NUM_PROCS, grant; request accepted when valid && ready.
- idx_valid_out / idx_data_out / idx_proc_out, output, 1 / 32 / PROC_BITS, IDX lane response.
- da_valid_out / da_data_out / da_proc_out, output, 1 / 32 / PROC_BITS, DATA_A lane response.
- db_valid_out / db_data_out / db_proc_out, output, 1 / 32 / PROC_BITS, DATA_B lane response.

Behaviour:
- Lane mapping:
  - kind = 1 requests go to IDX from any processor.
  - kind = 0 requests go to DATA_A from even processor IDs and to DATA_B from odd IDs (static split; both data ports serve the shared data array).
- Arbitration: each lane has an independent round-robin arbiter over its eligible requesters.
  - Grant search starts at ptr; after a grant to processor p, ptr <= p+1 mod NUM_PROCS.
  - With no grant, ptr holds.
  - At most one grant per lane per cycle, so at most 3 grants total.
- req_ready_out[p] is combinational from the current requests and ptr, asserted only for the granted p.
- Requesters hold valid, kind and addr stable until they see ready. Dropping valid before a grant is legal; the request is simply withdrawn.
- Address truncation: IDX uses addr[$clog2(IDX_DEPTH)-1:0]; DATA lanes use addr[$clog2(DATA_DEPTH)-1:0]. Upper bits are ignored.
- Response timing:
  - A grant in cycle t drives the lane RAM address in cycle t.
  - The lane's valid/data/proc outputs are asserted in cycle t+READ_LAT for exactly one cycle.
  - Tag and valid travel in a READ_LAT-deep shift register per lane.
- Throughput: a single lane sustains one grant per cycle; back-to-back grants produce back-to-back responses in order.
- No response backpressure: consumers must sample whenever *_valid_out is high.
- Reset values:
  - All *_valid_out = 0; *_proc_out = 0; *_data_out = 0 (RAM output registers reset).
  - All round-robin pointers = 0; tag pipelines cleared.
- Reset mid-operation: in-flight responses are dropped and never appear after reset deasserts. RAM contents are unaffected.
- The memories are read-only; write enables are tied low.
- Simultaneous requests from the same processor to two lanes are impossible, because each processor carries one request per cycle.

Optional Feature:
- Macro GMEM_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants_out [3 x 32]: per-lane grant counter.
  - Adds output stat_stalls_out [3 x 32]: per-lane count of cycles in which at least one eligible request was not granted.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package graph_mem_pkg holds:
  - typedef lane_e {LANE_IDX, LANE_DA, LANE_DB}
  - typedef req_kind_e {KIND_DATA = 0, KIND_IDX = 1}
  - constant GMEM_WORD_W = 32
  - struct resp_t {valid, data, proc}
- Sub-module rr_arbiter #(N): inputs req[N]; outputs grant[N] (one-hot) and grant_idx. It owns the pointer with async active-low reset and is instantiated once per lane.
- RAMs use the team's existing single-port and true dual-port RAM wrappers.

Test Plan:
- Single requester: proc 3 issues kind=1, addr=5 with IDX_INIT[5]=0x20 → ready in the same cycle; idx_valid_out one cycle at t+2 with data=0x20 and proc=3.
- Round-robin fairness: procs 0, 2 and 4 hold kind=0 data requests continuously → DATA_A grants cycle 0, 2, 4, 0, …, with no starvation across 9 cycles. DATA_B stays idle.
- Three lanes at once: proc 1 data addr 7, proc 2 data addr 8, proc 5 idx addr 0, all in one cycle → all three granted in that cycle. Responses appear at t+2 on db, da and idx lanes with tags 1, 2 and 5.
- Back-to-back streaming: proc 6 issues data addrs 0..15 consecutively → 16 consecutive da_valid_out cycles, in order, with data equal to DATA_INIT[0..15].
- Reset mid-flight: assert rst_n_in low one cycle after granting 2 requests → no *_valid_out ever rises for them; pointers = 0 after release.
- Withdrawal and truncation: proc 0 drops valid while losing arbitration → no response produced. Data addr 0x0001_4003 → returns DATA_INIT[0x0003].
